// File: rtl/s100_pkg.sv
// Shared types and constants for the S-100 bus-cycle master:
// FSM state encoding, status-bit encodings and default timing parameters.
package s100_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_STVAL,
    ST_STRB,
    ST_REC
  } state_t;

  localparam int DEF_WAIT_MIN = 0;
  localparam int DEF_TIMEOUT  = 255;

  // Status vector order is {sMEMR, sMWRT, sINP, sOUT}
  localparam logic [3:0] STAT_MEMR = 4'b1000;
  localparam logic [3:0] STAT_MWRT = 4'b0100;
  localparam logic [3:0] STAT_INP  = 4'b0010;
  localparam logic [3:0] STAT_OUT  = 4'b0001;

  function automatic logic [3:0] status_bits(input logic io, input logic write);
    case ({io, write})
      2'b00:   return STAT_MEMR;
      2'b01:   return STAT_MWRT;
      2'b10:   return STAT_INP;
      default: return STAT_OUT;
    endcase
  endfunction

endpackage

// File: rtl/s100_bus_cycle_if.sv
// Request/response handshake between a local requester (master) and the
// S-100 bus-cycle engine (slave).
interface s100_bus_cycle_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_io, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_io, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/s100_wait_timer.sv
// Strobe-phase timer: enforces the minimum strobe length before RDY is honoured
// and flags a timeout once the strobe has lasted TIMEOUT cycles.
module s100_wait_timer
  import s100_pkg::*;
#(
  parameter int WAIT_MIN = DEF_WAIT_MIN,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic pll0_2MHz,
  input  logic reset,
  input  logic strb,
  input  logic rdy,
  output logic done,
  output logic timed_out
);

  localparam logic [7:0] MIN_CNT  = 8'(WAIT_MIN);
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  // cnt_reg = strobe cycles already completed before the current one
  logic [7:0] cnt_reg;
  logic       min_done;
  logic       last_cycle;
  logic       ready_ok;

  always_ff @(posedge pll0_2MHz) begin
    if (reset || !strb)
      cnt_reg <= '0;
    else if (cnt_reg != 8'hFF)
      cnt_reg <= cnt_reg + 8'd1;
  end

  generate
    if (WAIT_MIN == 0) begin : g_no_min
      assign min_done = 1'b1;
    end else begin : g_min
      assign min_done = (cnt_reg >= MIN_CNT);
    end
    if (TIMEOUT <= 1) begin : g_to_first
      assign last_cycle = 1'b1;
    end else begin : g_to_count
      assign last_cycle = (cnt_reg >= LAST_CNT);
    end
  endgenerate

  assign ready_ok  = strb && min_done && rdy;
  assign timed_out = strb && !ready_ok && last_cycle;
  assign done      = ready_ok || timed_out;

endmodule

// File: rtl/s100_bus_cycle.sv
// S-100 bus master: turns one accepted request into a SYNC/STVAL/strobe/recovery
// bus cycle and returns read data or a timeout flag.
module s100_bus_cycle
  import s100_pkg::*;
#(
  parameter int WAIT_MIN = DEF_WAIT_MIN,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic               pll0_2MHz,
  input  logic               reset,
  s100_bus_cycle_if.slave    bus,
  input  logic               rdy,
  input  logic [7:0]         din,
  output logic [15:0]        S100adr0_15,
  output logic [3:0]         S100adr16_19,
  output logic [7:0]         dout,
  output logic               pSYNC,
  output logic               pSTVAL,
  output logic               pDBIN,
  output logic               n_pWR,
  output logic               sMEMR,
  output logic               sMWRT,
  output logic               sINP,
  output logic               sOUT,
  output logic               F_add_oe,
  output logic               F_bus_stat_oe,
  output logic               F_bus_ctl_oe
);

  state_t      state_reg, state_next;
  logic [19:0] addr_reg;
  logic [7:0]  dout_reg;
  logic        write_reg, io_reg;
  logic [7:0]  rdata_reg;
  logic        err_reg;
  logic        oe_reg;
  logic        accept, strb_done, timed_out;
  logic        ready_out, rsp_valid_out;
  logic [3:0]  status;

  assign accept = bus.req_valid && (state_reg == ST_IDLE);

  s100_wait_timer #(
    .WAIT_MIN (WAIT_MIN),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .pll0_2MHz (pll0_2MHz),
    .reset     (reset),
    .strb      (state_reg == ST_STRB),
    .rdy       (rdy),
    .done      (strb_done),
    .timed_out (timed_out)
  );

  always_ff @(posedge pll0_2MHz) begin
    if (reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_SYNC;
      ST_SYNC:  state_next = ST_STVAL;
      ST_STVAL: state_next = ST_STRB;
      ST_STRB:  if (strb_done) state_next = ST_REC;
      ST_REC:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_out     = 1'b0;
    rsp_valid_out = 1'b0;
    pSYNC         = 1'b0;
    pSTVAL        = 1'b1;
    pDBIN         = 1'b0;
    n_pWR         = 1'b1;
    status        = '0;
    case (state_reg)
      ST_IDLE:  ready_out = 1'b1;
      ST_SYNC: begin
        pSYNC  = 1'b1;
        status = status_bits(io_reg, write_reg);
      end
      ST_STVAL: begin
        pSYNC  = 1'b1;
        pSTVAL = 1'b0;
        status = status_bits(io_reg, write_reg);
      end
      ST_STRB: begin
        pDBIN  = !write_reg;
        n_pWR  = !write_reg;
        status = status_bits(io_reg, write_reg);
      end
      ST_REC: begin
        rsp_valid_out = 1'b1;
        status        = status_bits(io_reg, write_reg);
      end
      default: ;
    endcase
  end

  // Address and dout are latched at accept so they hold through IDLE afterwards
  always_ff @(posedge pll0_2MHz) begin
    if (reset) begin
      addr_reg  <= '0;
      dout_reg  <= '0;
      write_reg <= 1'b0;
      io_reg    <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg  <= bus.req_addr;
        dout_reg  <= bus.req_write ? bus.req_wdata : 8'h00;
        write_reg <= bus.req_write;
        io_reg    <= bus.req_io;
      end
      if (state_reg == ST_STRB && strb_done) begin
        err_reg   <= timed_out;
        rdata_reg <= timed_out ? 8'hFF : (write_reg ? 8'h00 : din);
      end
    end
  end

  always_ff @(posedge pll0_2MHz) begin
    if (reset)
      oe_reg <= 1'b1;
    else
      oe_reg <= 1'b0;
  end

  assign S100adr0_15 = addr_reg[15:0];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hi_addr
      assign S100adr16_19[gi] = addr_reg[19-gi];
    end
  endgenerate

  assign dout          = dout_reg;
  assign {sMEMR, sMWRT, sINP, sOUT} = status;
  assign F_add_oe      = oe_reg;
  assign F_bus_stat_oe = oe_reg;
  assign F_bus_ctl_oe  = oe_reg;

  assign bus.req_ready = ready_out;
  assign bus.rsp_valid = rsp_valid_out;
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;

endmodule

// File: tb/tb_s100_bus_cycle.sv
// Directed bench for s100_bus_cycle: reset state, read/write/IO cycles,
// wait states, timeout, back-to-back requests and mid-cycle reset.
module tb_s100_bus_cycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdy = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [15:0] S100adr0_15;
  logic [3:0]  S100adr16_19;
  logic [7:0]  dout;
  logic        pSYNC, pSTVAL, pDBIN, n_pWR;
  logic        sMEMR, sMWRT, sINP, sOUT;
  logic        F_add_oe, F_bus_stat_oe, F_bus_ctl_oe;

  s100_bus_cycle_if bif ();

  s100_bus_cycle #(.WAIT_MIN(0), .TIMEOUT(16)) dut (
    .pll0_2MHz     (clk),
    .reset         (reset),
    .bus           (bif),
    .rdy           (rdy),
    .din           (din),
    .S100adr0_15   (S100adr0_15),
    .S100adr16_19  (S100adr16_19),
    .dout          (dout),
    .pSYNC         (pSYNC),
    .pSTVAL        (pSTVAL),
    .pDBIN         (pDBIN),
    .n_pWR         (n_pWR),
    .sMEMR         (sMEMR),
    .sMWRT         (sMWRT),
    .sINP          (sINP),
    .sOUT          (sOUT),
    .F_add_oe      (F_add_oe),
    .F_bus_stat_oe (F_bus_stat_oe),
    .F_bus_ctl_oe  (F_bus_ctl_oe)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Results of the most recent bus_cycle call
  int          r_lat, r_sync, r_stval_lo, r_dbin, r_wr, r_dout_bad, r_stat_bad;
  logic        r_done, r_err, r_ready_before;
  logic [7:0]  r_rdata;
  logic [15:0] r_lo;
  logic [3:0]  r_hi;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one request; rdy is held low for the first rdy_low strobe cycles
  task automatic bus_cycle(input logic w, input logic io, input logic [19:0] a,
                           input logic [7:0] wd, input int rdy_low);
    logic [3:0] stat_exp;
    logic [7:0] dout_exp;
    int strb_n;
    stat_exp = {~io & ~w, ~io & w, io & ~w, io & w};
    dout_exp = w ? wd : 8'h00;
    strb_n = 0;
    r_sync = 0; r_stval_lo = 0; r_dbin = 0; r_wr = 0; r_dout_bad = 0; r_stat_bad = 0;
    r_done = 1'b0; r_err = 1'b0; r_rdata = 8'h00;
    bif.req_valid = 1'b1; bif.req_write = w; bif.req_io = io;
    bif.req_addr = a; bif.req_wdata = wd; rdy = 1'b0;
    r_ready_before = bif.req_ready;
    tick();
    bif.req_valid = 1'b0;
    r_lat = 1;
    r_lo = S100adr0_15;
    r_hi = S100adr16_19;
    for (int guard = 0; guard < 300; guard++) begin
      if ({sMEMR, sMWRT, sINP, sOUT} !== stat_exp) r_stat_bad++;
      if (dout !== dout_exp) r_dout_bad++;
      if (pSYNC) r_sync++;
      if (!pSTVAL) r_stval_lo++;
      if (pDBIN) r_dbin++;
      if (!n_pWR) r_wr++;
      if (bif.rsp_valid) begin
        r_done = 1'b1;
        r_rdata = bif.rsp_rdata;
        r_err = bif.rsp_err;
        break;
      end
      if (pDBIN || !n_pWR) begin
        strb_n++;
        rdy = (strb_n > rdy_low);
      end else begin
        rdy = 1'b0;
      end
      tick();
      r_lat++;
    end
    rdy = 1'b0;
    tick();
  endtask

  initial begin
    int acc[$];
    int rsp_n, ready_bad;
    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_io = 1'b0;
    bif.req_addr = '0; bif.req_wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_strobes", {pSYNC, pSTVAL, pDBIN, n_pWR}, 4'b0101);
    check("rst_status", {sMEMR, sMWRT, sINP, sOUT}, 4'b0000);
    check("rst_addr", {S100adr16_19, S100adr0_15}, 20'h00000);
    check("rst_dout", dout, 8'h00);
    check("rst_rsp", {bif.rsp_valid, bif.rsp_err, bif.rsp_rdata}, 10'h000);
    check("rst_oe", {F_add_oe, F_bus_stat_oe, F_bus_ctl_oe}, 3'b111);
    reset = 1'b0;
    tick();
    check("oe_after_rst", {F_add_oe, F_bus_stat_oe, F_bus_ctl_oe}, 3'b000);
    check("idle_ready", bif.req_ready, 1'b1);

    // Memory read, no wait
    din = 8'hA5;
    bus_cycle(1'b0, 1'b0, 20'h12345, 8'h00, 0);
    check("rd_ready", r_ready_before, 1'b1);
    check("rd_done", r_done, 1'b1);
    check("rd_latency", r_lat, 4);
    check("rd_sync_cycles", r_sync, 2);
    check("rd_stval_cycles", r_stval_lo, 1);
    check("rd_dbin_cycles", r_dbin, 1);
    check("rd_wr_cycles", r_wr, 0);
    check("rd_rdata", r_rdata, 8'hA5);
    check("rd_err", r_err, 1'b0);
    check("rd_addr_hi", r_hi, 4'b1000);
    check("rd_addr_lo", r_lo, 16'h2345);
    check("rd_status", r_stat_bad, 0);
    check("rd_dout", r_dout_bad, 0);
    check("idle_strobes", {pSYNC, pSTVAL, pDBIN, n_pWR, bif.rsp_valid}, 5'b01010);
    check("idle_status", {sMEMR, sMWRT, sINP, sOUT}, 4'b0000);
    check("idle_addr_hold", {S100adr16_19, S100adr0_15}, 20'h82345);

    // Memory write with three wait cycles
    bus_cycle(1'b1, 1'b0, 20'h00F0F, 8'h3C, 3);
    check("wr_done", r_done, 1'b1);
    check("wr_pwr_cycles", r_wr, 4);
    check("wr_dbin_cycles", r_dbin, 0);
    check("wr_latency", r_lat, 7);
    check("wr_status", r_stat_bad, 0);
    check("wr_dout", r_dout_bad, 0);
    check("wr_err", r_err, 1'b0);
    check("wr_dout_hold", dout, 8'h3C);

    // I/O read with rdy stuck low: timeout after 16 strobe cycles
    din = 8'h5A;
    bus_cycle(1'b0, 1'b1, 20'h00042, 8'h00, 1000);
    check("to_done", r_done, 1'b1);
    check("to_dbin_cycles", r_dbin, 16);
    check("to_err", r_err, 1'b1);
    check("to_rdata", r_rdata, 8'hFF);
    check("to_latency", r_lat, 19);
    check("to_status", r_stat_bad, 0);
    check("to_dout", r_dout_bad, 0);

    // Back-to-back I/O writes with req_valid held high
    rsp_n = 0;
    ready_bad = 0;
    bif.req_valid = 1'b1; bif.req_write = 1'b1; bif.req_io = 1'b1;
    bif.req_addr = 20'h000AA; bif.req_wdata = 8'h77; rdy = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (bif.req_ready) acc.push_back(c);
      if (bif.req_ready && (pSYNC || !pSTVAL || pDBIN || !n_pWR || sOUT)) ready_bad++;
      if (bif.rsp_valid) rsp_n++;
      tick();
    end
    bif.req_valid = 1'b0;
    for (int g = 0; g < 20; g++) begin
      if (bif.req_ready) break;
      tick();
    end
    check("b2b_accepts", acc.size(), 4);
    if (acc.size() >= 4) begin
      check("b2b_gap1", acc[1] - acc[0], 5);
      check("b2b_gap2", acc[2] - acc[1], 5);
      check("b2b_gap3", acc[3] - acc[2], 5);
    end
    check("b2b_rsp_count", rsp_n, 3);
    check("b2b_ready_idle_only", ready_bad, 0);
    check("b2b_drained", bif.req_ready, 1'b1);
    rdy = 1'b0;

    // Reset during the strobe phase aborts without a response
    bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_io = 1'b0;
    bif.req_addr = 20'h54321;
    tick();
    bif.req_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_in_strb", pDBIN, 1'b1);
    reset = 1'b1;
    tick();
    check("mid_rst_dbin", pDBIN, 1'b0);
    check("mid_rst_stval", pSTVAL, 1'b1);
    check("mid_rst_oe", {F_add_oe, F_bus_stat_oe, F_bus_ctl_oe}, 3'b111);
    check("mid_rst_rsp", bif.rsp_valid, 1'b0);
    check("mid_rst_addr", {S100adr16_19, S100adr0_15}, 20'h00000);
    tick();
    check("mid_rst_rsp2", bif.rsp_valid, 1'b0);
    reset = 1'b0;
    tick();
    check("mid_rel_oe", {F_add_oe, F_bus_stat_oe, F_bus_ctl_oe}, 3'b000);
    check("mid_rel_rsp", bif.rsp_valid, 1'b0);
    check("mid_rel_ready", bif.req_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/s100_bus_cycle.md
S100_BUS_CYCLE -- requirements
Module: s100_bus_cycle

Interface
REQ-001 Parameter WAIT_MIN, default 0: extra strobe cycles inserted before RDY is sampled (range 0..15).
REQ-002 Parameter TIMEOUT, default 255: maximum strobe cycles allowed before abort (range 1..255).
REQ-003 pll0_2MHz  in  1: sole clock; all logic on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 req_valid / req_ready  in / out  1 / 1: request handshake; transfer on a cycle with both high.
REQ-006 req_write  in  1: 1 = write, 0 = read.
REQ-007 req_io  in  1: 1 = I/O cycle, 0 = memory cycle.
REQ-008 req_addr  in  20: cycle address A19..A0.
REQ-009 req_wdata  in  8: write data.
REQ-010 rdy  in  1: S-100 RDY and XRDY ANDed externally; high = ready.
REQ-011 din  in  8: S-100 DI bus.
REQ-012 rsp_valid  out  1: one-cycle completion pulse.
REQ-013 rsp_rdata  out  8: read data, valid with rsp_valid.
REQ-014 rsp_err  out  1: timeout flag, valid with rsp_valid.
REQ-015 S100adr0_15  out  16: A15..A0.
REQ-016 S100adr16_19  out  4: reversed order; bit0 = A19 ... bit3 = A16.
REQ-017 dout  out  8: S-100 DO bus.
REQ-018 pSYNC, pSTVAL, pDBIN, n_pWR  out  1 each: pSYNC/pDBIN active-high; pSTVAL/n_pWR active-low.
REQ-019 sMEMR, sMWRT, sINP, sOUT  out  1 each: active-high status.
REQ-020 F_add_oe, F_bus_stat_oe, F_bus_ctl_oe  out  1 each: active-low driver enables.

Function
REQ-021 States: IDLE, SYNC, STVAL, STRB, REC; req_ready = 1 only in IDLE.
REQ-022 IDLE: accepting a request latches addr/wdata/write/io; next state SYNC.
REQ-023 SYNC (1 cycle): pSYNC=1, pSTVAL=1; address and status valid from this cycle through REC.
REQ-024 STVAL (1 cycle): pSYNC=1, pSTVAL=0.
REQ-025 STRB: pDBIN=1 on read, n_pWR=0 on write; dout driven with wdata from SYNC through REC on write, else 8'h00.
REQ-026 STRB lasts at least 1+WAIT_MIN cycles; from then on rdy is sampled each cycle; exit to REC on first edge where rdy=1.
REQ-027 A read captures din into rsp_rdata on the STRB exit edge.
REQ-028 STRB cycle count reaching TIMEOUT without rdy: exit to REC; rsp_err=1; rsp_rdata=8'hFF.
REQ-029 REC (1 cycle): strobes inactive, rsp_valid=1; next state IDLE.
REQ-030 Status: sMEMR=!io&!write; sMWRT=!io&write; sINP=io&!write; sOUT=io&write; all 0 in IDLE.
REQ-031 No-wait latency: accept edge -> SYNC, STVAL, STRB, REC = 4 cycles; minimum request-to-request period 5 cycles.
REQ-032 req_valid outside IDLE is ignored; no request is queued.
REQ-033 IDLE outputs: address and dout hold last values; pSYNC=0, pSTVAL=1, pDBIN=0, n_pWR=1.
REQ-034 Wait/timeout counter is 8 bits; it saturates and never wraps.

Reset
REQ-035 Reset forces IDLE, plus all of: pSYNC=0, pSTVAL=1, pDBIN=0, n_pWR=1, status=0, address=0, dout=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-036 All three F_*_oe are 1 during reset and 0 from the first cycle after reset deasserts.
REQ-037 Reset asserted mid-cycle aborts the cycle on the next edge with no rsp_valid.

Structure
REQ-038 Shared package s100_pkg holds the state enum, status-bit encodings and TIMEOUT/WAIT_MIN defaults.
REQ-039 One sub-module, s100_wait_timer, holds the minimum-wait and timeout counting; the FSM lives in s100_bus_cycle.

Verification
REQ-040 Read 0x12345, WAIT_MIN=0, rdy=1, din=0xA5 -> SYNC, STVAL, 1 pDBIN cycle, rsp_valid 4 cycles after accept; rsp_rdata=0xA5; S100adr16_19=4'b1000.
REQ-041 Memory write 0x0F0F data 0x3C, rdy held low 3 cycles -> n_pWR low 4 cycles; sMWRT=1; dout=0x3C throughout.
REQ-042 I/O read, rdy stuck low, TIMEOUT=16 -> pDBIN high exactly 16 cycles; rsp_err=1; rsp_rdata=0xFF.
REQ-043 req_valid held high continuously -> accepts spaced exactly 5 cycles; no request accepted outside IDLE.
REQ-044 Reset asserted in STRB -> next edge pDBIN=0, pSTVAL=1, OEs=1, no rsp_valid; OEs=0 one cycle after release.
